note_sequencer: RTL and testbench

- Reads a song's three 100-bit lane vectors (red, yellow, blue) and its total_notes count from the song loader, and plays them back one column per beat.
- Presents a look-ahead window of upcoming notes to the display path and one-cycle hit pulses to the scoring/judge path.
- Sits between the song loader and the renderer/scorer. Owns song progress, pause and end-of-song detection.

---
 rtl/note_sequencer_if.sv | 39 +++
 rtl/note_sequencer.sv | 147 ++++++++++++++
 tb/tb_note_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Bus between the sequencer and its song loader / renderer / scorer.
// The loader side drives control and song data; the sequencer drives playback state.
interface note_sequencer_if #(
  parameter int unsigned SONG_LEN = 100,
  parameter int unsigned WINDOW   = 8
);
  logic                start;
  logic                abort;
  logic                pause;
  logic [SONG_LEN-1:0] song_red;
  logic [SONG_LEN-1:0] song_yellow;
  logic [SONG_LEN-1:0] song_blue;
  logic [7:0]          song_total_notes;

  logic [WINDOW-1:0]   win_red;
  logic [WINDOW-1:0]   win_yellow;
  logic [WINDOW-1:0]   win_blue;
  logic                hit_red;
  logic                hit_yellow;
  logic                hit_blue;
  logic                beat_tick;
  logic [6:0]          position;
  logic [7:0]          notes_played;
  logic [7:0]          total_notes;
  logic                busy;
  logic                done;

  modport master (
    output start, abort, pause, song_red, song_yellow, song_blue, song_total_notes,
    input  win_red, win_yellow, win_blue, hit_red, hit_yellow, hit_blue,
           beat_tick, position, notes_played, total_notes, busy, done
  );

  modport slave (
    input  start, abort, pause, song_red, song_yellow, song_blue, song_total_notes,
    output win_red, win_yellow, win_blue, hit_red, hit_yellow, hit_blue,
           beat_tick, position, notes_played, total_notes, busy, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Plays back three lane vectors one column per beat, exposing a look-ahead
// window and one-cycle hit pulses; tracks progress, pause and end of song.
module note_sequencer #(
  parameter int unsigned SONG_LEN = 100,
  parameter int unsigned BEAT_DIV = 12500000,
  parameter int unsigned WINDOW   = 8
) (
  input  logic              clk,
  input  logic              resetn,
  note_sequencer_if.slave   bus
);

  localparam int unsigned CNT_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam int unsigned POS_W = 7;
  localparam int unsigned NP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SONG_LEN-1:0] red_q, red_d;
  logic [SONG_LEN-1:0] yellow_q, yellow_d;
  logic [SONG_LEN-1:0] blue_q, blue_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]    position_q, position_d;
  logic [NP_W-1:0]     notes_played_q, notes_played_d;
  logic [NP_W-1:0]     total_notes_q, total_notes_d;
  logic                hit_red_q, hit_red_d;
  logic                hit_yellow_q, hit_yellow_d;
  logic                hit_blue_q, hit_blue_d;
  logic                beat_tick_q, beat_tick_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      red_q          <= '0;
      yellow_q       <= '0;
      blue_q         <= '0;
      cnt_q          <= '0;
      position_q     <= '0;
      notes_played_q <= '0;
      total_notes_q  <= '0;
      hit_red_q      <= 1'b0;
      hit_yellow_q   <= 1'b0;
      hit_blue_q     <= 1'b0;
      beat_tick_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      red_q          <= red_d;
      yellow_q       <= yellow_d;
      blue_q         <= blue_d;
      cnt_q          <= cnt_d;
      position_q     <= position_d;
      notes_played_q <= notes_played_d;
      total_notes_q  <= total_notes_d;
      hit_red_q      <= hit_red_d;
      hit_yellow_q   <= hit_yellow_d;
      hit_blue_q     <= hit_blue_d;
      beat_tick_q    <= beat_tick_d;
    end
  end

  // Next-state and datapath; abort overrides everything but the latched note count
  always_comb begin
    state_d        = state_q;
    red_d          = red_q;
    yellow_d       = yellow_q;
    blue_d         = blue_q;
    cnt_d          = cnt_q;
    position_d     = position_q;
    notes_played_d = notes_played_q;
    total_notes_d  = total_notes_q;
    hit_red_d      = 1'b0;
    hit_yellow_d   = 1'b0;
    hit_blue_d     = 1'b0;
    beat_tick_d    = 1'b0;

    if (bus.abort) begin
      state_d        = ST_IDLE;
      red_d          = '0;
      yellow_d       = '0;
      blue_d         = '0;
      cnt_d          = '0;
      position_d     = '0;
      notes_played_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d        = ST_PLAY;
            red_d          = bus.song_red;
            yellow_d       = bus.song_yellow;
            blue_d         = bus.song_blue;
            total_notes_d  = bus.song_total_notes;
            cnt_d          = '0;
            position_d     = '0;
            notes_played_d = '0;
          end
        end
        ST_PLAY: begin
          if (!bus.pause) begin
            if (cnt_q == CNT_W'(BEAT_DIV - 1)) begin
              cnt_d        = '0;
              beat_tick_d  = 1'b1;
              hit_red_d    = red_q[SONG_LEN-1];
              hit_yellow_d = yellow_q[SONG_LEN-1];
              hit_blue_d   = blue_q[SONG_LEN-1];
              red_d        = red_q << 1;
              yellow_d     = yellow_q << 1;
              blue_d       = blue_q << 1;
              position_d   = position_q + POS_W'(1);
              if ((red_q[SONG_LEN-1] | yellow_q[SONG_LEN-1] | blue_q[SONG_LEN-1])
                  && (notes_played_q != {NP_W{1'b1}})) begin
                notes_played_d = notes_played_q + NP_W'(1);
              end
              if (position_q == POS_W'(SONG_LEN - 1)) begin
                state_d = ST_DONE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Windows come straight from the shadow registers, so they track each shift
  assign bus.win_red      = red_q[SONG_LEN-1 -: WINDOW];
  assign bus.win_yellow   = yellow_q[SONG_LEN-1 -: WINDOW];
  assign bus.win_blue     = blue_q[SONG_LEN-1 -: WINDOW];
  assign bus.hit_red      = hit_red_q;
  assign bus.hit_yellow   = hit_yellow_q;
  assign bus.hit_blue     = hit_blue_q;
  assign bus.beat_tick    = beat_tick_q;
  assign bus.position     = position_q;
  assign bus.notes_played = notes_played_q;
  assign bus.total_notes  = total_notes_q;
  assign bus.busy         = (state_q == ST_PLAY);
  assign bus.done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with BEAT_DIV=4, WINDOW=8, SONG_LEN=100.
module tb_note_sequencer;

  localparam int unsigned SONG_LEN = 100;
  localparam int unsigned WINDOW   = 8;
  localparam int unsigned BEAT_DIV = 4;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  note_sequencer_if #(.SONG_LEN(SONG_LEN), .WINDOW(WINDOW)) bus ();

  note_sequencer #(.SONG_LEN(SONG_LEN), .BEAT_DIV(BEAT_DIV), .WINDOW(WINDOW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs from PLAY entry until done, checking hit pulses against a shadow model
  task automatic run_song(input logic [99:0] mr, input logic [99:0] my, input logic [99:0] mb,
                          input int p_at, input int p_len,
                          output int ticks, output int done_cyc, output int gap_err,
                          output int hit_err, output int pause_tick);
    int last;
    int gap;
    logic paused;
    ticks = 0; done_cyc = -1; gap_err = 0; hit_err = 0; pause_tick = 0; last = 0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      paused    = (cyc > p_at) && (cyc <= p_at + p_len);
      bus.pause = paused;
      step(1);
      if (bus.beat_tick) begin
        ticks++;
        if (paused) pause_tick++;
        gap = cyc - last;
        if (!(gap == 4 || (p_len > 0 && gap == 4 + p_len))) gap_err++;
        last = cyc;
        if ({bus.hit_red, bus.hit_yellow, bus.hit_blue} != {mr[99], my[99], mb[99]}) hit_err++;
        mr = mr << 1;
        my = my << 1;
        mb = mb << 1;
      end else if (bus.hit_red | bus.hit_yellow | bus.hit_blue) begin
        hit_err++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
    end
    bus.pause = 1'b0;
  endtask

  task automatic load(input logic [99:0] r, input logic [99:0] y, input logic [99:0] b,
                      input logic [7:0] tn);
    bus.song_red = r; bus.song_yellow = y; bus.song_blue = b; bus.song_total_notes = tn;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  logic [99:0] alt;
  logic [99:0] msb1;
  int ticks, done_cyc, gap_err, hit_err, pause_tick, cnt;

  initial begin
    total = 0; bad = 0;
    alt  = {25{4'hA}};
    msb1 = 100'd1 << 99;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
    bus.song_red = '0; bus.song_yellow = '0; bus.song_blue = '0; bus.song_total_notes = '0;
    resetn = 1'b0;
    step(2);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_pos", bus.position, 7'd0);
    check("rst_win", bus.win_red, 8'h00);
    check("rst_tn", bus.total_notes, 8'd0);
    resetn = 1'b1;
    step(1);

    // 1: single red note at column 0
    load(msb1, '0, '0, 8'd5);
    check("t1_busy", bus.busy, 1'b1);
    check("t1_win_entry", bus.win_red, 8'h80);
    step(3);
    check("t1_hit_early", bus.hit_red, 1'b0);
    step(1);
    check("t1_hit", bus.hit_red, 1'b1);
    check("t1_tick", bus.beat_tick, 1'b1);
    check("t1_pos", bus.position, 7'd1);
    check("t1_np", bus.notes_played, 8'd1);
    check("t1_win_after", bus.win_red, 8'h00);
    step(1);
    check("t1_hit_pulse", bus.hit_red, 1'b0);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    check("t1_abort_busy", bus.busy, 1'b0);
    check("t1_abort_tn", bus.total_notes, 8'd5);

    // 2: full alternating song
    load(alt, '0, '0, 8'd90);
    check("t2_win_entry", bus.win_red, 8'hAA);
    run_song(alt, '0, '0, 0, 0, ticks, done_cyc, gap_err, hit_err, pause_tick);
    check("t2_ticks", ticks, 100);
    check("t2_done_cyc", done_cyc, 400);
    check("t2_gaps", gap_err, 0);
    check("t2_hits", hit_err, 0);
    check("t2_pos", bus.position, 7'd100);
    check("t2_np", bus.notes_played, 8'd50);
    check("t2_tn", bus.total_notes, 8'd90);
    check("t2_busy", bus.busy, 1'b0);
    step(2);
    check("t2_done_hold", bus.done, 1'b1);
    check("t2_quiet", {bus.beat_tick, bus.hit_red}, 2'b00);

    // 3: pause for 10 cycles mid-song; red and yellow lanes
    load(alt, ~alt, '0, 8'd100);
    run_song(alt, ~alt, '0, 49, 10, ticks, done_cyc, gap_err, hit_err, pause_tick);
    check("t3_ticks", ticks, 100);
    check("t3_done_cyc", done_cyc, 410);
    check("t3_gaps", gap_err, 0);
    check("t3_pause_tick", pause_tick, 0);
    check("t3_hits", hit_err, 0);
    check("t3_np", bus.notes_played, 8'd100);

    // 4: song inputs move during PLAY; restart from DONE loads the new song
    load(alt, '0, msb1, 8'd51);
    bus.song_red = '1; bus.song_yellow = '1; bus.song_blue = '1; bus.song_total_notes = 8'd7;
    run_song(alt, '0, msb1, 0, 0, ticks, done_cyc, gap_err, hit_err, pause_tick);
    check("t4_hits", hit_err, 0);
    check("t4_tn", bus.total_notes, 8'd51);
    check("t4_np", bus.notes_played, 8'd50);
    load('1, msb1, '0, 8'd200);
    check("t4_restart_busy", bus.busy, 1'b1);
    check("t4_restart_pos", bus.position, 7'd0);
    check("t4_restart_np", bus.notes_played, 8'd0);
    check("t4_restart_tn", bus.total_notes, 8'd200);
    check("t4_restart_win", {bus.win_red, bus.win_yellow}, 16'hFF80);

    // 5: abort at position 37, then start+abort together
    cnt = 0;
    while (bus.position != 7'd37 && cnt < 400) begin
      step(1);
      cnt++;
    end
    check("t5_reach37", bus.position, 7'd37);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    check("t5_idle", {bus.busy, bus.done}, 2'b00);
    check("t5_pos", bus.position, 7'd0);
    check("t5_win", {bus.win_red, bus.win_yellow, bus.win_blue}, 24'h0);
    check("t5_hit", {bus.hit_red, bus.hit_yellow, bus.hit_blue}, 3'b000);
    check("t5_tn_hold", bus.total_notes, 8'd200);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.beat_tick) cnt++;
    end
    check("t5_no_ticks", cnt, 0);
    load(alt, '0, '0, 8'd3);
    check("t5_play", bus.busy, 1'b1);
    bus.start = 1'b1; bus.abort = 1'b1;
    step(1);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("t5_sa_busy", bus.busy, 1'b0);
    check("t5_sa_win", bus.win_red, 8'h00);
    bus.start = 1'b1; bus.abort = 1'b1;
    step(1);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("t5_sa_idle", bus.busy, 1'b0);

    // 6: async reset mid-beat, then clean restart
    load(msb1, '0, '0, 8'd9);
    step(2);
    resetn = 1'b0;
    #2;
    check("t6_rst_busy", bus.busy, 1'b0);
    check("t6_rst_win", bus.win_red, 8'h00);
    check("t6_rst_tn", bus.total_notes, 8'd0);
    step(1);
    check("t6_rst_tick", {bus.beat_tick, bus.hit_red}, 2'b00);
    resetn = 1'b1;
    step(1);
    load(msb1, '0, '0, 8'd9);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (bus.beat_tick | bus.hit_red) cnt++;
    end
    check("t6_no_stale", cnt, 0);
    step(1);
    check("t6_hit", {bus.beat_tick, bus.hit_red}, 2'b11);
    check("t6_pos", bus.position, 7'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
